// File: rtl/tr_pkg.sv
// Shared types, default widths and the rate-curve mapping for the
// stepper tracking regulator.
package tr_pkg;

    localparam int DEF_WIDTH_IN   = 12;
    localparam int DEF_WIDTH_WORK = 16;
    localparam int DEF_PHASE_W    = 24;
    localparam int DEF_KSHIFT     = 4;
    localparam int DEF_POS_W      = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRACK,
        S_DEADZONE,
        S_REVERSE,
        S_DIR_WAIT
    } tr_state_t;

    localparam int WW = DEF_WIDTH_WORK;

    // Piecewise-linear rate curve; the sloped segment clamps at F2
    // and at the word maximum instead of wrapping.
    function automatic logic [WW-1:0] map_rate(
        input logic [WW-1:0] dx,
        input logic [WW-1:0] dx1,
        input logic [WW-1:0] dx2,
        input logic [WW-1:0] f1,
        input logic [WW-1:0] f2,
        input logic [WW-1:0] k
    );
        logic [WW-1:0]   span;
        logic [2*WW-1:0] prod;
        logic [2*WW:0]   sum;
        span = '0;
        prod = '0;
        sum  = '0;
        map_rate = f1;
        if (dx >= dx2) begin
            map_rate = f2;
        end else if (dx >= dx1) begin
            span = dx - dx1;
            prod = {{WW{1'b0}}, k} * {{WW{1'b0}}, span};
            sum  = {{(WW+1){1'b0}}, f1} + {1'b0, prod >> DEF_KSHIFT};
            if (sum > {{(WW+1){1'b0}}, f2})
                map_rate = f2;
            else if (sum > {{(WW+1){1'b0}}, {WW{1'b1}}})
                map_rate = '1;
            else
                map_rate = sum[WW-1:0];
        end
    endfunction

endpackage

// File: rtl/tr_stepper_ctrl_step_nco.sv
// Step NCO: phase accumulator whose carry launches a fixed-width
// step pulse; a pulse always runs to full width once started.
module step_nco
    import tr_pkg::*;
#(
    parameter int WIDTH_WORK = DEF_WIDTH_WORK,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int PULSE_W    = 50
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [WIDTH_WORK-1:0] rate,
    output logic                  drv_step,
    output logic                  carry
);

    localparam int CW = $clog2(PULSE_W + 1);
    localparam logic [CW-1:0] PW_LAST = CW'(PULSE_W - 1);

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W:0]   sum;
    logic [CW-1:0]      pw_cnt;
    logic               fire;

    assign sum  = {1'b0, phase}
                + {{(PHASE_W + 1 - WIDTH_WORK){1'b0}}, rate};
    assign fire = en && !clr && sum[PHASE_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= '0;
            carry    <= 1'b0;
            drv_step <= 1'b0;
            pw_cnt   <= '0;
        end else begin
            carry <= fire;
            if (clr)
                phase <= '0;
            else if (en)
                phase <= sum[PHASE_W-1:0];
            if (fire) begin
                drv_step <= 1'b1;
                pw_cnt   <= PW_LAST;
            end else if (pw_cnt != '0) begin
                pw_cnt <= pw_cnt - 1'b1;
            end else begin
                drv_step <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/tr_stepper_ctrl.sv
// Tracking regulator for a stepper axis: error -> rate curve ->
// slew limit -> NCO steps, with deadzone hysteresis and safe reversal.
module tr_stepper_ctrl
    import tr_pkg::*;
#(
    parameter int WIDTH_IN   = DEF_WIDTH_IN,
    parameter int WIDTH_WORK = DEF_WIDTH_WORK,
    parameter int PHASE_W    = DEF_PHASE_W,
    parameter int KSHIFT     = DEF_KSHIFT,
    parameter int DZ_IN      = 0,
    parameter int DZ_OUT     = 50,
    parameter int PULSE_W    = 50,
    parameter int DIR_SETUP  = 100,
    parameter int POS_W      = DEF_POS_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    data_valid,
    input  logic                    tr_mode_enable,
    input  logic [WIDTH_IN-1:0]     x0,
    input  logic [WIDTH_WORK-1:0]   x,
    input  logic [WIDTH_WORK-1:0]   dx1,
    input  logic [WIDTH_WORK-1:0]   dx2,
    input  logic [WIDTH_WORK-1:0]   F1,
    input  logic [WIDTH_WORK-1:0]   F2,
    input  logic [WIDTH_WORK-1:0]   k,
    input  logic [WIDTH_WORK-1:0]   acc_step,
    output logic [WIDTH_WORK-1:0]   rate,
    output logic                    drv_step,
    output logic                    drv_dir,
    output logic                    drv_enable_SM,
    output logic                    in_deadzone,
    output logic signed [POS_W-1:0] pos
);

    localparam int SW = $clog2(DIR_SETUP + 1);
    localparam logic [WIDTH_WORK-1:0] DZ_IN_W  = WIDTH_WORK'(DZ_IN);
    localparam logic [WIDTH_WORK-1:0] DZ_OUT_W = WIDTH_WORK'(DZ_OUT);
    localparam logic [SW-1:0]         SETUP_W  = SW'(DIR_SETUP);

    tr_state_t             state;
    logic [WIDTH_WORK-1:0] x0_ext;
    logic [WIDTH_WORK-1:0] dx;
    logic [WIDTH_WORK-1:0] map;
    logic [WIDTH_WORK-1:0] target;
    logic [WIDTH_WORK-1:0] rate_nxt;
    logic [SW-1:0]         setup_cnt;
    logic                  sgn;
    logic                  track_ok;
    logic                  ramp_pend;
    logic                  nco_en;
    logic                  nco_clr;
    logic                  carry;

    assign x0_ext   = {{(WIDTH_WORK - WIDTH_IN){1'b0}}, x0};
    assign sgn      = x < x0_ext;
    assign dx       = sgn ? x0_ext - x : x - x0_ext;
    assign map      = map_rate(dx, dx1, dx2, F1, F2, k);
    assign track_ok = state == S_TRACK && sgn == drv_dir && dx > DZ_IN_W;

    assign nco_en  = (state == S_TRACK || state == S_DEADZONE)
                   && setup_cnt == '0;
    assign nco_clr = state == S_IDLE;

    assign in_deadzone = state == S_DEADZONE;

    // Slew toward target by at most acc_step, landing exactly on it.
    always_comb begin
        rate_nxt = rate;
        if (target > rate)
            rate_nxt = (target - rate > acc_step) ? rate + acc_step : target;
        else if (rate > target)
            rate_nxt = (rate - target > acc_step) ? rate - acc_step : target;
    end

    step_nco #(
        .WIDTH_WORK (WIDTH_WORK),
        .PHASE_W    (PHASE_W),
        .PULSE_W    (PULSE_W)
    ) u_nco (
        .clk      (clk),
        .rst      (rst),
        .en       (nco_en),
        .clr      (nco_clr),
        .rate     (rate),
        .drv_step (drv_step),
        .carry    (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            target        <= '0;
            rate          <= '0;
            ramp_pend     <= 1'b0;
            setup_cnt     <= '0;
            drv_dir       <= 1'b0;
            drv_enable_SM <= 1'b0;
            pos           <= '0;
        end else begin
            ramp_pend <= data_valid;
            if (data_valid)
                target <= track_ok ? map : '0;
            if (ramp_pend)
                rate <= rate_nxt;
            if (carry)
                pos <= drv_dir ? pos + POS_W'(1) : pos - POS_W'(1);
            if (setup_cnt != '0)
                setup_cnt <= setup_cnt - 1'b1;
            if (state == S_IDLE) begin
                rate   <= '0;
                target <= '0;
            end

            if (!tr_mode_enable) begin
                state         <= S_IDLE;
                drv_enable_SM <= 1'b0;
                setup_cnt     <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state         <= S_TRACK;
                        drv_dir       <= sgn;
                        drv_enable_SM <= 1'b1;
                    end
                    S_TRACK: begin
                        if (data_valid) begin
                            if (dx <= DZ_IN_W)
                                state <= S_DEADZONE;
                            else if (sgn != drv_dir)
                                state <= S_REVERSE;
                        end
                    end
                    S_DEADZONE: begin
                        if (rate == '0)
                            drv_enable_SM <= 1'b0;
                        if (data_valid && dx >= DZ_OUT_W) begin
                            drv_enable_SM <= 1'b1;
                            state <= (sgn != drv_dir) ? S_REVERSE : S_TRACK;
                        end
                    end
                    S_REVERSE: begin
                        // Flip only once the motor is stopped and idle.
                        if (rate == '0 && !drv_step) begin
                            drv_dir   <= sgn;
                            setup_cnt <= SETUP_W;
                            state     <= S_DIR_WAIT;
                        end
                    end
                    S_DIR_WAIT: begin
                        if (setup_cnt == '0)
                            state <= S_TRACK;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tr_stepper_ctrl.sv
// Self-checking bench for tr_stepper_ctrl: scoreboarded rate per
// strobe plus step timing, deadzone, reversal and reset checks.
module tb_tr_stepper_ctrl;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               data_valid = 1'b0;
    logic               tr_mode_enable = 1'b0;
    logic [11:0]        x0 = 12'd1000;
    logic [15:0]        x = 16'd1600;
    logic [15:0]        dx1 = 16'd100;
    logic [15:0]        dx2 = 16'd1000;
    logic [15:0]        F1 = 16'd200;
    logic [15:0]        F2 = 16'd4000;
    logic [15:0]        k = 16'd32;
    logic [15:0]        acc_step = 16'hFFFF;
    logic [15:0]        rate;
    logic               drv_step;
    logic               drv_dir;
    logic               drv_enable_SM;
    logic               in_deadzone;
    logic signed [31:0] pos;

    int          n_chk = 0;
    int          n_fail = 0;
    int          m_rate = 0;
    longint      cyc = 0;
    logic [15:0] exp_q[$];

    tr_stepper_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .data_valid     (data_valid),
        .tr_mode_enable (tr_mode_enable),
        .x0             (x0),
        .x              (x),
        .dx1            (dx1),
        .dx2            (dx2),
        .F1             (F1),
        .F2             (F2),
        .k              (k),
        .acc_step       (acc_step),
        .rate           (rate),
        .drv_step       (drv_step),
        .drv_dir        (drv_dir),
        .drv_enable_SM  (drv_enable_SM),
        .in_deadzone    (in_deadzone),
        .pos            (pos)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int ref_map(int d);
        longint v;
        if (d >= int'(dx2)) return int'(F2);
        if (d < int'(dx1)) return int'(F1);
        v = longint'(F1) + (longint'(k) * longint'(d - int'(dx1))) / 16;
        if (v > longint'(F2)) v = longint'(F2);
        return int'(v);
    endfunction

    task automatic sb_strobe(input logic [15:0] xv, input int tgt,
                             input string tag);
        int a;
        a = int'(acc_step);
        if (tgt > m_rate)
            m_rate = (tgt - m_rate > a) ? m_rate + a : tgt;
        else if (m_rate > tgt)
            m_rate = (m_rate - tgt > a) ? m_rate - a : tgt;
        exp_q.push_back(16'(m_rate));
        @(negedge clk);
        x = xv;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        @(negedge clk);
        check(tag, rate, exp_q.pop_front());
    endtask

    task automatic wait_rise(input int budget, output bit ok);
        logic prev;
        ok = 1'b0;
        prev = drv_step;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (drv_step && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = drv_step;
        end
    endtask

    initial begin
        bit     ok;
        longint c1, c2;
        int     p1, p2, p0, hi, rises;
        logic   prev;

        repeat (3) @(negedge clk);
        check("rst_rate", rate, 0);
        check("rst_step", drv_step, 0);
        check("rst_dir", drv_dir, 0);
        check("rst_en", drv_enable_SM, 0);
        check("rst_dz", in_deadzone, 0);
        check("rst_pos", pos, 0);
        rst = 1'b0;

        // basic mapping and step timing
        tr_mode_enable = 1'b1;
        repeat (2) @(negedge clk);
        check("en_on", drv_enable_SM, 1);
        check("dir_pos_err", drv_dir, 0);
        sb_strobe(16'd1600, ref_map(600), "basic_rate");
        wait_rise(15000, ok);
        check("step1_seen", ok, 1);
        c1 = cyc;
        repeat (3) @(negedge clk);
        p1 = pos;
        check("pos_first", p1, -1);
        wait_rise(15000, ok);
        check("step2_seen", ok, 1);
        c2 = cyc;
        check("step_period", (c2 - c1 >= 13980 && c2 - c1 <= 13982), 1);
        hi = 1;
        repeat (3) begin
            @(negedge clk);
            hi += int'(drv_step);
        end
        p2 = pos;
        check("pos_dec", p2, p1 - 1);

        // enable drop mid-pulse: pulse finishes at full width
        tr_mode_enable = 1'b0;
        for (int i = 0; i < 200 && drv_step; i++) begin
            @(negedge clk);
            hi += int'(drv_step);
        end
        check("pulse_width", hi, 50);
        check("idle_en", drv_enable_SM, 0);
        check("idle_rate", rate, 0);
        m_rate = 0;

        // ramp limit
        acc_step = 16'd100;
        tr_mode_enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 14; i++)
            sb_strobe(16'd1600, ref_map(600), "ramp_rate");

        // deadzone hysteresis
        acc_step = 16'hFFFF;
        sb_strobe(16'd1000, 0, "dz_enter_rate");
        @(negedge clk);
        check("dz_flag", in_deadzone, 1);
        check("dz_en_off", drv_enable_SM, 0);
        sb_strobe(16'd1049, 0, "dz_hold_rate");
        check("dz_hold_flag", in_deadzone, 1);
        check("dz_hold_en", drv_enable_SM, 0);
        sb_strobe(16'd1050, 0, "dz_exit_rate");
        check("dz_exit_flag", in_deadzone, 0);
        check("dz_exit_en", drv_enable_SM, 1);
        sb_strobe(16'd1050, ref_map(50), "track_low");

        // reversal
        sb_strobe(16'd1200, ref_map(200), "rev_pre_rate");
        sb_strobe(16'd700, 0, "rev_stop_rate");
        for (int i = 0; i < 20 && !drv_dir; i++) @(negedge clk);
        check("rev_dir", drv_dir, 1);
        p0 = pos;
        rises = 0;
        prev = drv_step;
        repeat (100) begin
            @(negedge clk);
            if (drv_step && !prev) rises++;
            prev = drv_step;
        end
        check("rev_no_steps", rises, 0);
        check("rev_pos_hold", pos, p0);
        repeat (10) @(negedge clk);
        sb_strobe(16'd700, ref_map(300), "rev_rate");
        wait_rise(30000, ok);
        check("rev_step_seen", ok, 1);
        repeat (3) @(negedge clk);
        check("pos_inc", pos, p0 + 1);

        // saturation and curve boundaries
        k = 16'hFFFF;
        sb_strobe(16'd1, ref_map(999), "sat_999");
        sb_strobe(16'd899, ref_map(101), "sat_101");
        k = 16'd32;
        sb_strobe(16'd900, ref_map(100), "knee_dx1");
        sb_strobe(16'd1, ref_map(999), "slope_999");
        sb_strobe(16'd0, ref_map(1000), "knee_dx2");

        // synchronous reset mid-pulse
        wait_rise(6000, ok);
        check("rst_step_seen", ok, 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_step", drv_step, 0);
        check("rst2_pos", pos, 0);
        check("rst2_rate", rate, 0);
        check("rst2_en", drv_enable_SM, 0);
        check("rst2_dir", drv_dir, 0);
        rst = 1'b0;
        tr_mode_enable = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
